// File: rtl/exec_unit_p.sv
// exec_unit_p: multi-cycle barrel shift / ALU / NZCV execute unit with valid/ready channels.
// Define EXEC_MUL_EN to add an iterative shift-add multiply selected by in_mul.
module exec_unit_p #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [7:0]      in_shamt,
    input  logic [2:0]      in_shop,
    input  logic [3:0]      in_aluop,
    input  logic            in_s,
    input  logic            in_mul,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_wr,
    output logic [3:0]      nzcv
);
    localparam int SW = $clog2(XLEN);

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

    state_t state, state_d;

    logic [XLEN-1:0] a_q, b_q, result_q;
    logic [7:0]      shamt_q;
    logic [2:0]      shop_q;
    logic [3:0]      aluop_q, nzcv_q;
    logic            s_q, wr_q;

    logic [XLEN:0]     lsl_w, lsr_w, asr_w;
    logic [2*XLEN-1:0] ror_w;
    logic [XLEN-1:0]   sh_res;
    logic              sh_c, cin;

    logic [XLEN-1:0] x, y, logic_f, alu_f;
    logic [XLEN:0]   sum;
    logic            ci, arith, alu_c, alu_v;

`ifdef EXEC_MUL_EN
    logic [XLEN-1:0] acc, mul_sum;
    logic [SW-1:0]   cnt;
    logic            mul_last;
    assign mul_sum  = acc + (b_q[0] ? a_q : '0);
    assign mul_last = cnt == SW'(XLEN - 1);
`else
    logic unused_mul;
    assign unused_mul = in_mul;
`endif

    assign cin        = nzcv_q[1];
    assign in_ready   = state == IDLE;
    assign out_valid  = state == DONE;
    assign out_result = result_q;
    assign out_wr     = wr_q;
    assign nzcv       = nzcv_q;

    // Barrel shifter on the latched B; the extra bit in each wide vector captures the carry-out
    always_comb begin
        lsl_w  = {1'b0, b_q} << shamt_q;
        lsr_w  = {b_q, 1'b0} >> shamt_q;
        asr_w  = $unsigned($signed({b_q, 1'b0}) >>> shamt_q);
        ror_w  = {b_q, b_q} >> shamt_q[SW-1:0];
        sh_res = b_q;
        sh_c   = cin;
        if (shop_q == 3'd4) begin
            sh_res = {cin, b_q[XLEN-1:1]};
            sh_c   = b_q[0];
        end else if (shamt_q != 8'd0) begin
            case (shop_q)
                3'd0: {sh_c, sh_res} = lsl_w;
                3'd1: {sh_res, sh_c} = lsr_w;
                3'd2: {sh_res, sh_c} = asr_w;
                3'd3: begin
                    sh_res = ror_w[XLEN-1:0];
                    sh_c   = ror_w[XLEN-1];
                end
                default: ;
            endcase
        end
    end

    // ALU: arithmetic ops share one adder with optional operand swap/invert; logical ops take the shifter carry
    always_comb begin
        x     = a_q;
        y     = sh_res;
        ci    = 1'b0;
        arith = 1'b1;
        case (aluop_q)
            4'd2, 4'd10: begin
                y  = ~sh_res;
                ci = 1'b1;
            end
            4'd3: begin
                x  = sh_res;
                y  = ~a_q;
                ci = 1'b1;
            end
            4'd4, 4'd11: ;
            4'd5: ci = cin;
            4'd6: begin
                y  = ~sh_res;
                ci = cin;
            end
            4'd7: begin
                x  = sh_res;
                y  = ~a_q;
                ci = cin;
            end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{XLEN{1'b0}}, ci};
        case (aluop_q)
            4'd0, 4'd8: logic_f = a_q & sh_res;
            4'd1, 4'd9: logic_f = a_q ^ sh_res;
            4'd12:      logic_f = a_q | sh_res;
            4'd13:      logic_f = sh_res;
            4'd14:      logic_f = a_q & ~sh_res;
            default:    logic_f = ~sh_res;
        endcase
        alu_f = arith ? sum[XLEN-1:0] : logic_f;
        alu_c = arith ? sum[XLEN] : sh_c;
        alu_v = arith ? (x[XLEN-1] == y[XLEN-1]) && (alu_f[XLEN-1] != x[XLEN-1]) : nzcv_q[0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state sequencing: IDLE -> EXEC (or MUL) -> DONE -> IDLE on output handshake
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (in_valid) begin
                state_d = EXEC;
`ifdef EXEC_MUL_EN
                if (in_mul) state_d = MUL;
`endif
            end
            EXEC: state_d = DONE;
`ifdef EXEC_MUL_EN
            MUL: if (mul_last) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latches, result/writeback registers and the architectural flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            shop_q   <= '0;
            aluop_q  <= '0;
            s_q      <= 1'b0;
            result_q <= '0;
            wr_q     <= 1'b0;
            nzcv_q   <= '0;
`ifdef EXEC_MUL_EN
            acc      <= '0;
            cnt      <= '0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                a_q     <= in_a;
                b_q     <= in_b;
                shamt_q <= in_shamt;
                shop_q  <= in_shop;
                aluop_q <= in_aluop;
                s_q     <= in_s;
`ifdef EXEC_MUL_EN
                acc     <= '0;
                cnt     <= '0;
`endif
            end
            if (state == EXEC) begin
                result_q <= alu_f;
                wr_q     <= aluop_q[3:2] != 2'b10;
                if (s_q) nzcv_q <= {alu_f[XLEN-1], alu_f == '0, alu_c, alu_v};
            end
`ifdef EXEC_MUL_EN
            if (state == MUL) begin
                acc <= mul_sum;
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
                cnt <= cnt + 1'b1;
                if (mul_last) begin
                    result_q <= mul_sum;
                    wr_q     <= 1'b1;
                    if (s_q) nzcv_q[3:2] <= {mul_sum[XLEN-1], mul_sum == '0};
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_exec_unit_p.sv
// tb_exec_unit_p: directed vectors with hand-computed results for exec_unit_p at XLEN=32.
module tb_exec_unit_p;
    localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROR = 3'd3, RRX = 3'd4;
    localparam logic [3:0] EOR = 4'd1, SUB = 4'd2, RSB = 4'd3, ADD = 4'd4, ADC = 4'd5, SBC = 4'd6;
    localparam logic [3:0] TEQ = 4'd9, CMP = 4'd10, MOV = 4'd13, BIC = 4'd14, MVN = 4'd15;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_s = 1'b0, in_mul = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, out_result;
    logic [7:0]  in_shamt = '0;
    logic [2:0]  in_shop = '0;
    logic [3:0]  in_aluop = '0, nzcv;
    logic        out_valid, out_ready = 1'b0, out_wr;
    int          n_vec = 0, n_bad = 0;

    exec_unit_p #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_shop(in_shop),
        .in_aluop(in_aluop), .in_s(in_s), .in_mul(in_mul),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wr(out_wr), .nzcv(nzcv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one op, check it is accepted, scramble the inputs, and check out_valid rises after lat cycles
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [7:0] sh,
                         input logic [2:0] shop, input logic [3:0] alu, input logic s, input logic mul, input int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_shamt = sh; in_shop = shop; in_aluop = alu; in_s = s; in_mul = mul;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_shamt = ~sh; in_aluop = ~alu; in_s = ~s;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({tag, ".busy"}, {in_ready, out_valid}, 0);
        end
        @(negedge clk);
        chk({tag, ".out_valid"}, out_valid, 1);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] f, input logic [3:0] fl, input logic wr);
        chk({tag, ".f"}, out_result, f);
        chk({tag, ".nzcv"}, nzcv, fl);
        chk({tag, ".wr"}, out_wr, wr);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".ready_after"}, {in_ready, out_valid}, 2'b10);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [7:0] sh,
                      input logic [2:0] shop, input logic [3:0] alu, input logic s,
                      input logic [31:0] f, input logic [3:0] fl, input logic wr);
        issue(tag, a, b, sh, shop, alu, s, 1'b0, 2);
        expect_out(tag, f, fl, wr);
        retire(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        expect_out("reset", 32'h0, 4'b0000, 1'b0);

        op("add_ovf",  32'h7FFFFFFF, 32'h1,        8'd0,  LSL, ADD, 1'b1, 32'h80000000, 4'b1001, 1'b1);
        op("lsr32",    32'h0,        32'h80000000, 8'd32, LSR, MOV, 1'b1, 32'h0,        4'b0111, 1'b1);
        op("sub_eq",   32'h5,        32'h5,        8'd0,  LSL, SUB, 1'b1, 32'h0,        4'b0110, 1'b1);
        op("asr40",    32'h0,        32'h80000000, 8'd40, ASR, MOV, 1'b1, 32'hFFFFFFFF, 4'b1010, 1'b1);
        op("cmp_eq",   32'h5,        32'h5,        8'd0,  LSL, CMP, 1'b1, 32'h0,        4'b0110, 1'b0);
        op("rrx",      32'h0,        32'h1,        8'd0,  RRX, MOV, 1'b1, 32'h80000000, 4'b1010, 1'b1);
        op("lsl1",     32'h0,        32'h80000000, 8'd1,  LSL, MOV, 1'b1, 32'h0,        4'b0110, 1'b1);
        op("ror32",    32'h0,        32'h80000001, 8'd32, ROR, MOV, 1'b1, 32'h80000001, 4'b1010, 1'b1);
        op("ror4",     32'h0,        32'h0000000F, 8'd4,  ROR, MOV, 1'b1, 32'hF0000000, 4'b1010, 1'b1);
        op("eor_nos",  32'hFF00FF00, 32'h0F0F0F0F, 8'd0,  LSL, EOR, 1'b0, 32'hF00FF00F, 4'b1010, 1'b1);
        op("adc",      32'h1,        32'h1,        8'd0,  LSL, ADC, 1'b1, 32'h3,        4'b0000, 1'b1);
        op("lsl33",    32'h0,        32'hFFFFFFFF, 8'd33, LSL, MOV, 1'b1, 32'h0,        4'b0100, 1'b1);
        op("sbc",      32'h5,        32'h3,        8'd0,  LSL, SBC, 1'b1, 32'h1,        4'b0010, 1'b1);
        op("rsb",      32'h3,        32'hA,        8'd0,  LSL, RSB, 1'b1, 32'h7,        4'b0010, 1'b1);
        op("sub_ovf",  32'h80000000, 32'h1,        8'd0,  LSL, SUB, 1'b1, 32'h7FFFFFFF, 4'b0011, 1'b1);
        op("bic_nos",  32'h000000FF, 32'h0000000F, 8'd0,  LSL, BIC, 1'b0, 32'h000000F0, 4'b0011, 1'b1);
        op("teq",      32'h55,       32'h55,       8'd0,  LSL, TEQ, 1'b1, 32'h0,        4'b0111, 1'b0);
`ifdef EXEC_MUL_EN
        issue("mul", 32'h00010000, 32'h00010001, 8'd0, LSL, ADD, 1'b1, 1'b1, 33);
        expect_out("mul", 32'h00010000, 4'b0011, 1'b1);
        retire("mul");
`else
        issue("mul_ign", 32'h2, 32'h3, 8'd0, LSL, ADD, 1'b0, 1'b1, 2);
        expect_out("mul_ign", 32'h5, 4'b0111, 1'b1);
        retire("mul_ign");
`endif
        issue("bp", 32'h2, 32'h3, 8'd0, LSL, ADD, 1'b1, 1'b0, 2);
        in_a = '0; in_b = '0; in_shamt = '0; in_shop = LSL; in_aluop = MOV; in_s = 1'b1; in_mul = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold_valid", {in_ready, out_valid}, 2'b01);
            expect_out("bp.hold", 32'h5, 4'b0000, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp.ready_after", {in_ready, out_valid}, 2'b10);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp2.busy", {in_ready, out_valid}, 0);
        @(negedge clk);
        chk("bp2.out_valid", out_valid, 1);
        expect_out("bp2", 32'h0, 4'b0100, 1'b1);
        retire("bp2");

        op("mvn", 32'h0, 32'h0, 8'd0, LSL, MVN, 1'b1, 32'hFFFFFFFF, 4'b1000, 1'b1);

        @(negedge clk);
        in_a = 32'hFFFFFFFF; in_b = 32'h1; in_shamt = '0; in_shop = LSL; in_aluop = ADD; in_s = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rst_exec.busy", {in_ready, out_valid}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_exec.state", {in_ready, out_valid}, 2'b10);
        expect_out("rst_exec", 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        chk("rst_exec.stay_idle", {in_ready, out_valid}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
